// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_pkg
// Description : Shared sizing helpers and control types for fifo_stream_reader.
// Revision    : 1.0
// ============================================================================
package fifo_stream_pkg;

    localparam int c_MAX_LATENCY = 8;
    localparam int c_CNT_W       = 4;

    // Push/pop strobes handed from the credit logic to the output buffer.
    typedef struct packed {
        logic push;
        logic pop;
    } buf_ctl_t;

    // Smallest buffer that keeps a stream at full rate across the read latency.
    function automatic int buf_depth_for(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic logic [c_CNT_W-1:0] popcount(input logic [c_MAX_LATENCY-1:0] v);
        logic [c_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < c_MAX_LATENCY; i++) begin
            n = n + c_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_buf
// Description : DEPTH x DWIDTH circular buffer with push/pop, occupancy, head.
// Revision    : 1.0
// ============================================================================
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 3,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  buf_ctl_t          i_ctl,
    input  logic [DWIDTH-1:0] i_din,
    output logic [DWIDTH-1:0] o_head,
    output logic [OCC_W-1:0]  o_occ
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_ctl.push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_ctl.pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_ctl.push, i_ctl.pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_ctl.push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

    a_occ_bounded: assert property (@(posedge clk) disable iff (rst)
        r_occ <= OCC_W'(DEPTH));

    a_no_overflow_push: assert property (@(posedge clk) disable iff (rst)
        !(i_ctl.push && !i_ctl.pop && (r_occ == OCC_W'(DEPTH))));

    a_no_underflow_pop: assert property (@(posedge clk) disable iff (rst)
        !(i_ctl.pop && (r_occ == '0)));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a non-showahead fifo read port into a valid/ready stream.
// Revision    : 1.0
// ============================================================================
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = buf_depth_for(READ_LATENCY)
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic                           fifo_empty_i,
    input  logic [DWIDTH-1:0]              fifo_q_i,
    output logic                           fifo_rdreq_o,
    output logic [DWIDTH-1:0]              data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level_o
);

    localparam int c_LVL_W = $clog2(BUF_DEPTH + 1);
    localparam int c_SUM_W = c_CNT_W + c_LVL_W;

    logic [READ_LATENCY-1:0]  r_inflight;
    logic [c_MAX_LATENCY-1:0] w_inflight_ext;
    logic [c_SUM_W-1:0]       w_credits_used;
    logic [c_LVL_W-1:0]       w_occ;
    logic                     w_rdreq;
    logic                     w_capture;
    logic                     w_pop;
    buf_ctl_t                 w_ctl;

    // Credits count both held words and reads whose data is still in the fifo pipe,
    // so the buffer can never be over-committed and ready_i stays off this path.
    assign w_inflight_ext = c_MAX_LATENCY'(r_inflight);
    assign w_credits_used = c_SUM_W'(w_occ) + c_SUM_W'(popcount(w_inflight_ext));
    assign w_rdreq        = !fifo_empty_i && (w_credits_used < c_SUM_W'(BUF_DEPTH));

    assign w_capture = r_inflight[READ_LATENCY-1];
    assign w_pop     = valid_o && ready_i;
    assign w_ctl     = '{push: w_capture, pop: w_pop};

    if (READ_LATENCY == 1) begin : g_pipe_single
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= w_rdreq;
            end
        end
    end else begin : g_pipe_shift
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= {r_inflight[READ_LATENCY-2:0], w_rdreq};
            end
        end
    end

    fifo_stream_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (BUF_DEPTH),
        .OCC_W  (c_LVL_W)
    ) u_buf (
        .clk    (clk_i),
        .rst    (srst_i),
        .i_ctl  (w_ctl),
        .i_din  (fifo_q_i),
        .o_head (data_o),
        .o_occ  (w_occ)
    );

    assign fifo_rdreq_o = w_rdreq;
    assign valid_o      = (w_occ != '0);
    assign level_o      = w_occ;

endmodule
`default_nettype wire
